// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, load formatting and writeback select
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall_i, flush_i        hold WB contents / load a bubble (flush wins)
//   mem_*                   memory-stage outputs captured into WB
//   wb_valid                WB slot holds a real instruction
//   wb_rd_addr, wb_rd_data  register-file write address and data (always driven)
//   wb_reg_write_en         register-file write strobe
//   wb_load_misaligned      load in WB has a misaligned address (write suppressed)
//   instret                 retired-instruction counter

module mem_wb_stage #(
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_wb_dmem_data_out,
    input  logic [31:0]              mem_wb_alu_result,
    input  logic [4:0]               mem_wb_rd_addr,
    input  logic                     mem_wb_reg_write_en,
    input  logic [1:0]               mem_wb_mem_to_reg,
    input  logic [2:0]               mem_funct3,
    input  logic [31:0]              mem_pc_plus4,
    output logic                     wb_valid,
    output logic [4:0]               wb_rd_addr,
    output logic [31:0]              wb_rd_data,
    output logic                     wb_reg_write_en,
    output logic                     wb_load_misaligned,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                     r_valid;
    logic [31:0]              r_alu_result;
    logic [31:0]              r_load_word;
    logic [4:0]               r_rd_addr;
    logic                     r_reg_write_en;
    logic [1:0]               r_mem_to_reg;
    logic [2:0]               r_funct3;
    logic [31:0]              r_pc_plus4;
    logic [INSTRET_WIDTH-1:0] r_instret;

    logic [1:0]  w_byte_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_misaligned;
    logic [31:0] w_wb_data;

    // Pipeline register. Flush only needs to kill valid and the write strobe;
    // the remaining fields are left as they were since a bubble ignores them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_alu_result   <= '0;
            r_load_word    <= '0;
            r_rd_addr      <= '0;
            r_reg_write_en <= 1'b0;
            r_mem_to_reg   <= '0;
            r_funct3       <= '0;
            r_pc_plus4     <= '0;
        end else if (flush_i) begin
            r_valid        <= 1'b0;
            r_reg_write_en <= 1'b0;
        end else if (!stall_i) begin
            r_valid        <= mem_valid;
            r_alu_result   <= mem_wb_alu_result;
            r_load_word    <= mem_wb_dmem_data_out;
            r_rd_addr      <= mem_wb_rd_addr;
            r_reg_write_en <= mem_wb_reg_write_en;
            r_mem_to_reg   <= mem_wb_mem_to_reg;
            r_funct3       <= mem_funct3;
            r_pc_plus4     <= mem_pc_plus4;
        end
    end

    // An instruction retires on the edge that moves it out of WB; a stalled
    // one has not left yet, so it is counted on the release edge instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (r_valid && !stall_i) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
        end
    end

    assign w_byte_off = r_alu_result[1:0];

    always_comb begin
        w_byte = r_load_word[7:0];
        case (w_byte_off)
            2'd0:    w_byte = r_load_word[7:0];
            2'd1:    w_byte = r_load_word[15:8];
            2'd2:    w_byte = r_load_word[23:16];
            default: w_byte = r_load_word[31:24];
        endcase
    end

    assign w_half = w_byte_off[1] ? r_load_word[31:16] : r_load_word[15:0];

    // Unused funct3 codes fall through to a full-word load.
    always_comb begin
        w_load_data = r_load_word;
        case (r_funct3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_load_data = {24'd0, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = r_load_word;
        endcase
    end

    assign w_is_byte = (r_funct3 == F3_LB) || (r_funct3 == F3_LBU);
    assign w_is_half = (r_funct3 == F3_LH) || (r_funct3 == F3_LHU);

    // Anything that is neither a byte nor a halfword access is a word access
    // and needs both offset bits clear. Bubbles never report a misalignment.
    assign w_misaligned = r_valid && (r_mem_to_reg == SEL_LOAD) &&
                          ((w_is_half && w_byte_off[0]) ||
                           (!w_is_byte && !w_is_half && (w_byte_off != 2'd0)));

    always_comb begin
        w_wb_data = r_alu_result;
        case (r_mem_to_reg)
            SEL_ALU:  w_wb_data = r_alu_result;
            SEL_LOAD: w_wb_data = w_load_data;
            SEL_PC4:  w_wb_data = r_pc_plus4;
            default:  w_wb_data = r_alu_result;
        endcase
    end

    assign wb_valid           = r_valid;
    assign wb_rd_addr         = r_rd_addr;
    assign wb_rd_data         = w_wb_data;
    assign wb_load_misaligned = w_misaligned;
    assign wb_reg_write_en    = r_valid && r_reg_write_en &&
                                (r_rd_addr != 5'd0) && !w_misaligned;
    assign instret            = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        mem_valid;
    logic [31:0] mem_wb_dmem_data_out;
    logic [31:0] mem_wb_alu_result;
    logic [4:0]  mem_wb_rd_addr;
    logic        mem_wb_reg_write_en;
    logic [1:0]  mem_wb_mem_to_reg;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_pc_plus4;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        wb_reg_write_en;
    logic        wb_load_misaligned;
    logic [63:0] instret;

    always #5 clk = ~clk;

    mem_wb_stage #(.INSTRET_WIDTH(64)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall_i              (stall_i),
        .flush_i              (flush_i),
        .mem_valid            (mem_valid),
        .mem_wb_dmem_data_out (mem_wb_dmem_data_out),
        .mem_wb_alu_result    (mem_wb_alu_result),
        .mem_wb_rd_addr       (mem_wb_rd_addr),
        .mem_wb_reg_write_en  (mem_wb_reg_write_en),
        .mem_wb_mem_to_reg    (mem_wb_mem_to_reg),
        .mem_funct3           (mem_funct3),
        .mem_pc_plus4         (mem_pc_plus4),
        .wb_valid             (wb_valid),
        .wb_rd_addr           (wb_rd_addr),
        .wb_rd_data           (wb_rd_data),
        .wb_reg_write_en      (wb_reg_write_en),
        .wb_load_misaligned   (wb_load_misaligned),
        .instret              (instret)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        mis;
        logic        full;   // 0: only valid/we are meaningful (bubble)
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_instret = 64'd0;
    logic        cur_valid = 1'b0;

    localparam logic [31:0] WORD = 32'h80F0_7F01;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step(input logic stall, input logic flush);
        stall_i = stall;
        flush_i = flush;
        @(posedge clk);
        if (cur_valid && !stall) exp_instret++;
        #1;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, {63'd0, wb_valid}, {63'd0, e.valid});
        chk({tag, ".we"}, {63'd0, wb_reg_write_en}, {63'd0, e.we});
        if (e.full) begin
            chk({tag, ".rd"}, {59'd0, wb_rd_addr}, {59'd0, e.rd});
            chk({tag, ".data"}, {32'd0, wb_rd_data}, {32'd0, e.data});
            chk({tag, ".mis"}, {63'd0, wb_load_misaligned}, {63'd0, e.mis});
        end
        chk({tag, ".instret"}, instret, exp_instret);
        cur_valid = e.valid;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] dmem,
                         input logic [31:0] pc);
        mem_valid            = v;
        mem_wb_rd_addr       = rd;
        mem_wb_reg_write_en  = we;
        mem_wb_mem_to_reg    = sel;
        mem_funct3           = f3;
        mem_wb_alu_result    = alu;
        mem_wb_dmem_data_out = dmem;
        mem_pc_plus4         = pc;
    endtask

    task automatic issue(input string tag, input logic v, input logic [4:0] rd,
                         input logic we, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] dmem,
                         input logic [31:0] pc, input logic [31:0] e_data,
                         input logic e_we, input logic e_mis);
        exp_t e;
        drive(v, rd, we, sel, f3, alu, dmem, pc);
        e = '{valid: v, rd: rd, data: e_data, we: e_we, mis: e_mis, full: 1'b1};
        sb.push_back(e);
        last_exp = e;
        edge_step(1'b0, 1'b0);
        compare_out(tag);
    endtask

    task automatic stall_cycle(input string tag);
        drive(1'b1, 5'($urandom), 1'b1, 2'($urandom), 3'($urandom),
              $urandom, $urandom, $urandom);
        sb.push_back(last_exp);
        edge_step(1'b1, 1'b0);
        compare_out(tag);
    endtask

    task automatic flush_cycle(input string tag, input logic stall);
        exp_t e;
        drive(1'b1, 5'd9, 1'b1, 2'b00, 3'b010, 32'h0000_0999, 32'd0, 32'd0);
        e = '{valid: 1'b0, rd: 5'd0, data: 32'd0, we: 1'b0, mis: 1'b0, full: 1'b0};
        sb.push_back(e);
        edge_step(stall, 1'b1);
        compare_out(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, ".we"}, {63'd0, wb_reg_write_en}, 64'd0);
        chk({tag, ".mis"}, {63'd0, wb_load_misaligned}, 64'd0);
        chk({tag, ".rd"}, {59'd0, wb_rd_addr}, 64'd0);
        chk({tag, ".data"}, {32'd0, wb_rd_data}, 64'd0);
        chk({tag, ".instret"}, instret, 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue("alu_wr",  1, 5'd5, 1, 2'b00, 3'b010, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0010, 32'h1234_5678, 1, 0);
        issue("lb3",     1, 5'd6, 1, 2'b01, 3'b000, 32'h0000_1003, WORD, 32'h14, 32'hFFFF_FF80, 1, 0);
        issue("lbu3",    1, 5'd6, 1, 2'b01, 3'b100, 32'h0000_1003, WORD, 32'h18, 32'h0000_0080, 1, 0);
        issue("lb1",     1, 5'd7, 1, 2'b01, 3'b000, 32'h0000_1001, WORD, 32'h1C, 32'h0000_007F, 1, 0);
        issue("lh2",     1, 5'd8, 1, 2'b01, 3'b001, 32'h0000_1002, WORD, 32'h20, 32'hFFFF_80F0, 1, 0);
        issue("lhu0",    1, 5'd8, 1, 2'b01, 3'b101, 32'h0000_1000, WORD, 32'h24, 32'h0000_7F01, 1, 0);
        issue("lhu2",    1, 5'd8, 1, 2'b01, 3'b101, 32'h0000_1002, WORD, 32'h28, 32'h0000_80F0, 1, 0);
        issue("lw0",     1, 5'd9, 1, 2'b01, 3'b010, 32'h0000_1000, WORD, 32'h2C, 32'h80F0_7F01, 1, 0);
        issue("f3_011",  1, 5'd9, 1, 2'b01, 3'b011, 32'h0000_1000, WORD, 32'h30, 32'h80F0_7F01, 1, 0);
        issue("lw_mis",  1, 5'd10, 1, 2'b01, 3'b010, 32'h0000_1002, WORD, 32'h34, 32'h80F0_7F01, 0, 1);
        issue("lh_mis",  1, 5'd10, 1, 2'b01, 3'b001, 32'h0000_1001, WORD, 32'h38, 32'h0000_7F01, 0, 1);
        issue("x0_pc4",  1, 5'd0, 1, 2'b10, 3'b010, 32'h0000_0050, WORD, 32'h0000_0104, 32'h0000_0104, 0, 0);
        issue("sel11",   1, 5'd11, 1, 2'b11, 3'b010, 32'hA5A5_0003, WORD, 32'h40, 32'hA5A5_0003, 1, 0);
        issue("alu_odd", 1, 5'd12, 1, 2'b00, 3'b010, 32'h0000_1003, WORD, 32'h44, 32'h0000_1003, 1, 0);
        issue("no_we",   1, 5'd13, 0, 2'b00, 3'b010, 32'h0000_0077, WORD, 32'h48, 32'h0000_0077, 0, 0);
        issue("bubble",  0, 5'd14, 1, 2'b00, 3'b010, 32'h0000_0066, WORD, 32'h4C, 32'h0000_0066, 0, 0);

        issue("pre_stall", 1, 5'd15, 1, 2'b00, 3'b010, 32'h0000_CAFE, WORD, 32'h50, 32'h0000_CAFE, 1, 0);
        stall_cycle("stall1");
        stall_cycle("stall2");
        stall_cycle("stall3");
        issue("release", 1, 5'd16, 1, 2'b01, 3'b100, 32'h0000_2002, WORD, 32'h54, 32'h0000_00F0, 1, 0);

        flush_cycle("flush_stall", 1'b1);
        issue("after_fs", 1, 5'd17, 1, 2'b00, 3'b010, 32'h0000_0123, WORD, 32'h58, 32'h0000_0123, 1, 0);
        flush_cycle("flush_only", 1'b0);
        issue("after_fl", 1, 5'd18, 1, 2'b10, 3'b010, 32'h0000_0000, WORD, 32'h0000_0200, 32'h0000_0200, 1, 0);

        stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_instret = 64'd0;
        cur_valid   = 1'b0;
        sb.delete();
        @(negedge clk);
        stall_i = 1'b0;
        rst_n   = 1'b1;
        issue("post_rst", 1, 5'd19, 1, 2'b00, 3'b010, 32'h0BAD_F00D, WORD, 32'h60, 32'h0BAD_F00D, 1, 0);
        issue("post_rst2", 1, 5'd20, 1, 2'b00, 3'b010, 32'h0000_0001, WORD, 32'h64, 32'h0000_0001, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
